// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
//
// Two-master / one-slave Wishbone classic (single-beat) arbiter. It shares
// one memory port between the CPU instruction port (instr_*) and data port
// (data_*). Address, write data and we come from the granted master. Ack and
// read data go back to that master only. A slave-timeout watchdog completes
// a stalled transfer so that a missing ack cannot hang the CPU.
//
// Parameters
//   ADDR_W       address width, all ports
//   DATA_W       data width, all ports
//   TIMEOUT_CYC  grant cycles without mem_ack_i before forced completion
//                (0 disables the watchdog)
//
// Build option
//   WB_ARB_RR_EN  when defined, simultaneous requests alternate between the
//                 masters (grant goes to the master not granted last).
//                 When undefined, the data master always wins.
//
// Ports
//   sys_clk, sys_rst           clock; synchronous active-low reset
//   instr_addr_i/stb_i/we_i    instruction master request
//   instr_data_o/ack_o         instruction master response
//   data_addr_i/data_i/stb_i/we_i  data master request
//   data_data_o/ack_o          data master response
//   mem_addr_o/data_o/stb_o/we_o   slave request
//   mem_data_i/ack_i           slave response
//   arb_timeout_o              one-cycle pulse on watchdog expiry
// -----------------------------------------------------------------------------
module wb_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  // instruction master
  input  logic [ADDR_W-1:0] instr_addr_i,
  input  logic              instr_stb_i,
  input  logic              instr_we_i,
  output logic [DATA_W-1:0] instr_data_o,
  output logic              instr_ack_o,
  // data master
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_data_i,
  input  logic              data_stb_i,
  input  logic              data_we_i,
  output logic [DATA_W-1:0] data_data_o,
  output logic              data_ack_o,
  // slave
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_stb_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  // status
  output logic              arb_timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  // The counter only needs to reach TIMEOUT_CYC-1.
  localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit              WDOG_EN  = (TIMEOUT_CYC > 0);

  state_t           state;
  logic [CNT_W-1:0] wdog_cnt;

  logic busy;      // a master currently owns the slave port
  logic sel_d;     // the owner is the data master
  logic req_stb;   // strobe of the current owner
  logic expire;    // watchdog fires this cycle
  logic pick_d;    // IDLE arbitration result: grant the data master

  // Outputs are also held at zero during reset, so nothing leaks out on the
  // reset cycle itself before the state register returns to IDLE.
  assign busy    = sys_rst && (state != IDLE);
  assign sel_d   = (state == GNT_D);
  assign req_stb = sel_d ? data_stb_i : instr_stb_i;

  // A real ack on the expiry cycle wins. A master that has already dropped
  // its strobe is aborting, so it gets no forced ack either.
  assign expire = WDOG_EN && busy && req_stb && !mem_ack_i && (wdog_cnt == CNT_LAST);

`ifdef WB_ARB_RR_EN
  logic last_d;    // last grant went to the data master

  assign pick_d = data_stb_i && (!instr_stb_i || !last_d);
`else
  assign pick_d = data_stb_i;
`endif

  // Combinational port mux driven from the registered state.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the
    // branches below can leave a value held and infer a latch.
    mem_addr_o    = '0;
    mem_data_o    = '0;
    mem_stb_o     = 1'b0;
    mem_we_o      = 1'b0;
    instr_data_o  = '0;
    instr_ack_o   = 1'b0;
    data_data_o   = '0;
    data_ack_o    = 1'b0;
    arb_timeout_o = 1'b0;
    if (busy) begin
      mem_addr_o    = sel_d ? data_addr_i : instr_addr_i;
      mem_we_o      = sel_d ? data_we_i : instr_we_i;
      mem_data_o    = sel_d ? data_data_i : '0;
      mem_stb_o     = req_stb && !expire;
      arb_timeout_o = expire;
      if (sel_d) begin
        data_ack_o  = mem_ack_i || expire;
        data_data_o = expire ? '0 : mem_data_i;
      end else begin
        instr_ack_o  = mem_ack_i || expire;
        instr_data_o = expire ? '0 : mem_data_i;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments, so every register in this
  // block samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state    <= IDLE;
      wdog_cnt <= '0;
`ifdef WB_ARB_RR_EN
      last_d   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A stray mem_ack_i here is ignored. A grant only takes effect on
          // the next cycle.
          if (data_stb_i || instr_stb_i) begin
            state    <= pick_d ? GNT_D : GNT_I;
            wdog_cnt <= '0;
`ifdef WB_ARB_RR_EN
            last_d   <= pick_d;
`endif
          end
        end
        GNT_I, GNT_D: begin
          // Each way out (completion, abort or timeout) passes through IDLE.
          // The resulting bubble stops a strobe still high in the ack cycle
          // from being taken as a new request.
          if (mem_ack_i || !req_stb || expire) begin
            state <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_bus_arbiter
//
// Directed bench for wb_bus_arbiter with TIMEOUT_CYC = 4. Inputs change 1 ns
// after the rising edge. Outputs are sampled 1 ns later, which is well away
// from the next edge. Expected values are hand-derived constants. Define
// WB_ARB_RR_EN for both bench and RTL to check the round-robin build.
// -----------------------------------------------------------------------------
module tb_wb_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [ADDR_W-1:0] instr_addr_i;
  logic              instr_stb_i;
  logic              instr_we_i;
  logic [DATA_W-1:0] instr_data_o;
  logic              instr_ack_o;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_data_i;
  logic              data_stb_i;
  logic              data_we_i;
  logic [DATA_W-1:0] data_data_o;
  logic              data_ack_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_stb_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic              arb_timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  wb_bus_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (4)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .instr_addr_i  (instr_addr_i),
    .instr_stb_i   (instr_stb_i),
    .instr_we_i    (instr_we_i),
    .instr_data_o  (instr_data_o),
    .instr_ack_o   (instr_ack_o),
    .data_addr_i   (data_addr_i),
    .data_data_i   (data_data_i),
    .data_stb_i    (data_stb_i),
    .data_we_i     (data_we_i),
    .data_data_o   (data_data_o),
    .data_ack_o    (data_ack_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_stb_o     (mem_stb_o),
    .mem_we_o      (mem_we_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i),
    .arb_timeout_o (arb_timeout_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " ctl"}, 64'({mem_stb_o, mem_we_o, instr_ack_o, data_ack_o, arb_timeout_o}), 64'd0);
    check({tag, " bus"}, {mem_addr_o, mem_data_o}, 64'd0);
    check({tag, " rd"},  {instr_data_o, data_data_o}, 64'd0);
  endtask

  // Expected winners for four back-to-back contended transfers
  // (1 = data master). The previous grant went to the instruction master.
  bit exp_d [4];

  initial begin
`ifdef WB_ARB_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    sys_rst      = 1'b0;
    instr_addr_i = '0;
    instr_stb_i  = 1'b0;
    instr_we_i   = 1'b0;
    data_addr_i  = '0;
    data_data_i  = '0;
    data_stb_i   = 1'b0;
    data_we_i    = 1'b0;
    mem_data_i   = '0;
    mem_ack_i    = 1'b0;

    // ---- reset ----
    tick();
    tick();
    settle();
    check_quiet("reset");
    sys_rst = 1'b1;
    tick();

    // ---- 1: instruction read, slave acks on 3rd grant cycle ----
    instr_addr_i = 32'h100;
    instr_stb_i  = 1'b1;
    settle();
    check("t1 idle no stb", 64'(mem_stb_o), 64'd0);
    tick();                                    // grant cycle 1
    settle();
    check("t1 stb/addr", {31'd0, mem_stb_o, mem_addr_o}, {31'd0, 1'b1, 32'h100});
    check("t1 wdata", 64'(mem_data_o), 64'd0);
    tick();                                    // grant cycle 2
    settle();
    check("t1 no ack yet", 64'({instr_ack_o, data_ack_o}), 64'd0);
    tick();                                    // grant cycle 3: ack
    mem_ack_i  = 1'b1;
    mem_data_i = 32'hA5A5_0001;
    settle();
    check("t1 ack", 64'({instr_ack_o, data_ack_o, arb_timeout_o}), 64'b100);
    check("t1 rdata", 64'(instr_data_o), 64'hA5A5_0001);
    tick();                                    // bubble
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    settle();
    check("t1 bubble", 64'({mem_stb_o, instr_ack_o}), 64'd0);
    instr_stb_i = 1'b0;
    tick();

    // ---- 3: both masters requesting continuously ----
    instr_addr_i = 32'h300;
    data_addr_i  = 32'h400;
    data_data_i  = 32'h0000_D0D0;
    instr_stb_i  = 1'b1;
    data_stb_i   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("t3 idle", 64'(mem_stb_o), 64'd0);
      tick();                                  // grant cycle 1
      settle();
      check($sformatf("t3 grant%0d addr", k), 64'(mem_addr_o), exp_d[k] ? 64'h400 : 64'h300);
      check($sformatf("t3 grant%0d wdata", k), 64'(mem_data_o), exp_d[k] ? 64'hD0D0 : 64'h0);
      tick();                                  // grant cycle 2: ack
      mem_ack_i = 1'b1;
      settle();
      check($sformatf("t3 grant%0d ack", k), 64'({instr_ack_o, data_ack_o}),
            exp_d[k] ? 64'b01 : 64'b10);
      tick();                                  // back to IDLE
      mem_ack_i = 1'b0;
    end
    instr_stb_i = 1'b0;
    data_stb_i  = 1'b0;
    tick();

    // ---- 2: data write ----
    data_addr_i = 32'h200;
    data_data_i = 32'h1234_5678;
    data_we_i   = 1'b1;
    data_stb_i  = 1'b1;
    tick();
    settle();
    check("t2 addr", 64'(mem_addr_o), 64'h200);
    check("t2 we/stb", 64'({mem_we_o, mem_stb_o}), 64'b11);
    check("t2 wdata", 64'(mem_data_o), 64'h1234_5678);
    mem_ack_i = 1'b1;
    settle();
    check("t2 ack", 64'({instr_ack_o, data_ack_o}), 64'b01);
    tick();
    settle();
    check("t2 single pulse", 64'(data_ack_o), 64'd0);
    mem_ack_i  = 1'b0;
    data_stb_i = 1'b0;
    data_we_i  = 1'b0;
    tick();

    // ---- 4: watchdog, slave never acks ----
    instr_addr_i = 32'h500;
    instr_stb_i  = 1'b1;
    mem_data_i   = 32'hDEAD_BEEF;
    tick();                                    // grant cycle 1
    for (int c = 1; c < 4; c++) begin
      settle();
      check($sformatf("t4 cyc%0d wait", c), 64'({mem_stb_o, instr_ack_o, arb_timeout_o}), 64'b100);
      tick();
    end
    settle();                                  // grant cycle 4: expiry
    check("t4 expire", 64'({mem_stb_o, instr_ack_o, arb_timeout_o}), 64'b011);
    check("t4 rdata zero", 64'(instr_data_o), 64'd0);
    tick();                                    // bubble
    settle();
    check("t4 after", 64'({mem_stb_o, instr_ack_o, arb_timeout_o}), 64'd0);
    tick();                                    // normal re-grant
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h0000_0077;
    settle();
    check("t4 regrant", 64'({mem_stb_o, instr_ack_o, arb_timeout_o}), 64'b110);
    check("t4 regrant data", 64'(instr_data_o), 64'h77);
    tick();
    mem_ack_i   = 1'b0;
    mem_data_i  = '0;
    instr_stb_i = 1'b0;
    tick();

    // ---- 5: reset during a data grant ----
    data_addr_i = 32'h600;
    data_data_i = 32'h0000_CAFE;
    data_we_i   = 1'b1;
    data_stb_i  = 1'b1;
    tick();
    settle();
    check("t5 granted", 64'(mem_stb_o), 64'd1);
    sys_rst = 1'b0;
    tick();
    settle();
    check_quiet("t5 in reset");
    sys_rst    = 1'b1;
    data_stb_i = 1'b0;
    data_we_i  = 1'b0;
    mem_ack_i  = 1'b1;
    settle();
    check("t5 dropped", 64'({data_ack_o, mem_stb_o}), 64'd0);
    tick();
    mem_ack_i    = 1'b0;
    instr_addr_i = 32'h700;
    instr_stb_i  = 1'b1;
    tick();
    settle();
    check("t5 new grant", {31'd0, mem_stb_o, mem_addr_o}, {31'd0, 1'b1, 32'h700});
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h0000_005A;
    settle();
    check("t5 new ack", {31'd0, instr_ack_o, instr_data_o}, {31'd0, 1'b1, 32'h5A});
    tick();
    mem_ack_i   = 1'b0;
    mem_data_i  = '0;
    instr_stb_i = 1'b0;
    tick();

    // ---- 6: stray ack in IDLE, data master aborts mid-grant ----
    data_addr_i = 32'h800;
    data_stb_i  = 1'b1;
    mem_ack_i   = 1'b1;
    mem_data_i  = 32'h0000_0099;
    settle();
    check("t6 stray ack", {30'd0, instr_ack_o, data_ack_o, data_data_o}, 64'd0);
    tick();                                    // GNT_D
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    settle();
    check("t6 granted", 64'(mem_stb_o), 64'd1);
    data_stb_i   = 1'b0;
    instr_addr_i = 32'h900;
    instr_stb_i  = 1'b1;
    settle();
    check("t6 abort", 64'({mem_stb_o, data_ack_o, instr_ack_o}), 64'd0);
    tick();                                    // IDLE after abort
    settle();
    check("t6 idle", 64'(mem_stb_o), 64'd0);
    tick();                                    // instr granted
    settle();
    check("t6 instr grant", {31'd0, mem_stb_o, mem_addr_o}, {31'd0, 1'b1, 32'h900});
    mem_ack_i = 1'b1;
    settle();
    check("t6 instr ack", 64'({instr_ack_o, data_ack_o}), 64'b10);
    tick();
    mem_ack_i   = 1'b0;
    instr_stb_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
